rot_word_loader: RTL and testbench
==================================

// Module: rot_word_loader
// PURPOSE
//   Upstream feeder for the log2_N-stage rotator ("rot").
//   Accepts an N-bit operand as N/W narrow beats over a valid/ready stream and assembles it in a register.
//   Captures the rotate amount k with the first beat.
//   Presents the completed {bits, k} pair, registered, on a valid/ready output that drives rot.bits / rot.k directly.
// PARAMETERS
//   N       256  operand width in bits; power of two
//   log2_N  8    log2(N); width of rotate amount
//   W       32   beat width; power of two, W <= N, N % W == 0
//   BEATS is derived as N/W; a beat counter of width max(1, log2(BEATS)) holds it.
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           reset; asynchronous, active-high
//   abort      in   1           synchronous discard of any partial or held word
//   in_valid   in   1           beat valid
//   in_ready   out  1           loader can accept a beat this cycle
//   in_data    in   [0:W-1]     beat payload; index 0 = lowest operand index
//   in_k       in   [0:log2_N-1] rotate amount; sampled on first beat only
//   out_valid  out  1           assembled word available
//   out_ready  in   1           downstream (rotator consumer) accepts word
//   out_bits   out  [0:N-1]     assembled operand -> rot.bits
//   out_k      out  [0:log2_N-1] captured amount -> rot.k
//   beat_cnt   out  [..]        beats accepted for the current word (debug/status)
// BEHAVIOUR
//   Reset: state=IDLE, out_valid=0, out_bits=0, out_k=0, beat_cnt=0. in_ready=1 after reset.
//   Transfer rules:
//     - Input beat transfers when in_valid & in_ready.
//     - Output transfers when out_valid & out_ready.
//     - in_valid must not depend on in_ready; out_valid never depends on out_ready.
//   Beat placement: beat j (0-based) writes out_bits[j*W +: W], with in_data[0] -> out_bits[j*W].
//   FSM:
//     - IDLE:
//         - in_ready=1.
//         - On a transfer: load beat 0, capture in_k into out_k, beat_cnt=1.
//         - Then go FILL, or go HOLD directly if BEATS==1.
//     - FILL:
//         - in_ready=1.
//         - Each transfer loads beat beat_cnt and increments it.
//         - On the transfer of beat BEATS-1: beat_cnt wraps to 0, state goes HOLD.
//     - HOLD:
//         - out_valid=1; out_bits/out_k are stable until the output transfer.
//         - in_ready=out_ready (pass-through accept).
//         - Output transfer with no input transfer: go IDLE.
//         - Output transfer and input transfer in the same cycle: the new beat 0 loads, new k is captured, go FILL (or stay HOLD if BEATS==1). No idle bubble.
//   Latency: out_valid rises the cycle after the final beat transfers. Sustained throughput is 1 word per BEATS cycles.
//   in_k on beats 1..BEATS-1 is ignored.
//   out_bits bits not yet written in FILL are don't-care and are not observable (out_valid=0).
//   abort (priority over all transfers):
//     - Next state is IDLE, beat_cnt=0, out_valid=0.
//     - in_ready is forced 0 in the abort cycle; no beat is consumed.
//     - out_bits/out_k keep their values.
//   Reset mid-word: asynchronous return to reset values; the partial word is lost.
//   BEATS counter wrap is exact; no overflow state exists.
//   Rotation itself is done downstream: out_bits[i] after rot = out_bits[(i-k) mod N].
// TESTING (N=8, log2_N=3, W=2 unless noted)
//   - Reset mid-FILL: assert rst after 2 beats -> out_valid=0 and beat_cnt=0 immediately; a fresh 4-beat word then assembles correctly.
//   - Basic load:
//       - Stimulus: beats 10,11,00,01 with in_k=3 on beat 0; out_ready=1.
//       - Required: out_valid one cycle after the 4th beat; out_bits=8'b10110001, out_k=3.
//       - Chained through rot: result 8'b00110110.
//   - Backpressure:
//       - Stimulus: hold out_ready=0 for 5 cycles in HOLD.
//       - Required: out_bits and out_k stable; in_ready=0; extra in_valid beats are not consumed.
//       - When out_ready=1: the word transfers once.
//   - Back-to-back:
//       - Stimulus: the new beat 0 is presented in the same cycle as the output transfer.
//       - Required: the beat is accepted and the next word's out_valid arrives exactly 4 cycles later.
//   - Abort:
//       - Stimulus: abort after 2 beats.
//       - Required: no out_valid; the next 4 beats form a clean word with the new in_k.
//       - Also: abort in HOLD drops out_valid the next cycle.
//   - k sampling: change in_k on beats 1..3 -> out_k equals the beat-0 value.
//   - W=N (BEATS=1): every accepted beat yields out_valid next cycle; throughput 1 word/cycle while out_ready=1.

Source files
------------

// File: rtl/rot_word_loader.sv
// Narrow-beat operand assembler feeding the rot rotator.
// Collects N/W beats plus the beat-0 rotate amount, then holds the word.
module rot_word_loader #(
  parameter  int N      = 256,
  parameter  int log2_N = 8,
  parameter  int W      = 32,
  localparam int BEATS  = N / W,
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:W-1]      in_data,
  input  logic [0:log2_N-1] in_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits,
  output logic [0:log2_N-1] out_k,
  output logic [CW-1:0]     beat_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_t;

  localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);
  localparam logic [CW-1:0] FIRST = (BEATS == 1) ? '0 : CW'(1);

  state_t        state;
  logic          in_fire;
  logic          out_fire;
  logic          first;
  logic [CW-1:0] wr_idx;

  assign in_ready = !abort && (state != HOLD || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    first  = 1'b0;
    wr_idx = '0;
    if (state == FILL) begin
      wr_idx = beat_cnt;
    end else begin
      first = in_fire;
    end
  end

  // Data path: in_fire is already masked by abort through in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_bits <= '0;
      out_k    <= '0;
    end else if (in_fire) begin
      for (int j = 0; j < BEATS; j++) begin
        if (wr_idx == CW'(j)) begin
          out_bits[j*W +: W] <= in_data;
        end
      end
      if (first) begin
        out_k <= in_k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            beat_cnt <= FIRST;
            if (BEATS == 1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (in_fire) begin
            if (beat_cnt == LAST) begin
              beat_cnt  <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            if (in_fire) begin
              beat_cnt <= FIRST;
              if (BEATS == 1) begin
                state     <= HOLD;
                out_valid <= 1'b1;
              end else begin
                state     <= FILL;
                out_valid <= 1'b0;
              end
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          beat_cnt  <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rot_word_loader.sv
// Directed bench for rot_word_loader: N=8/W=2 instance and a W=N instance.
// Expected values are hand-computed constants.
module tb_rot_word_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [0:1] in_data;
  logic [0:2] in_k;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] out_bits;
  logic [0:2] out_k;
  logic [1:0] beat_cnt;

  logic       abort1;
  logic       in_valid1;
  logic       in_ready1;
  logic [0:7] in_data1;
  logic [0:2] in_k1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:7] out_bits1;
  logic [0:2] out_k1;
  logic [0:0] beat_cnt1;

  int errs   = 0;
  int checks = 0;
  int xfers  = 0;
  int x0;

  always #5 clk = ~clk;

  rot_word_loader #(.N(8), .log2_N(3), .W(2)) u_dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_k(out_k),
    .beat_cnt(beat_cnt)
  );

  rot_word_loader #(.N(8), .log2_N(3), .W(8)) u_dut1 (
    .clk(clk), .rst(rst), .abort(abort1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_k(in_k1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_bits(out_bits1), .out_k(out_k1),
    .beat_cnt(beat_cnt1)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) xfers++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [0:1] d, input logic [0:2] k);
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [0:7] rot8(input logic [0:7] b, input int k);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[i] = b[(i - k + 8) % 8];
    return r;
  endfunction

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    in_k = '0; out_ready = 1'b0;
    abort1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    in_k1 = '0; out_ready1 = 1'b0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_bits", out_bits, 0);
    chk("rst_k", out_k, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);

    // reset mid-FILL
    beat(2'b11, 3'd2);
    beat(2'b01, 3'd2);
    chk("mid_cnt", beat_cnt, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", beat_cnt, 0);
    #1 rst = 1'b0;
    step();

    // basic load
    out_ready = 1'b1;
    beat(2'b10, 3'd3);
    beat(2'b11, 3'd3);
    beat(2'b00, 3'd3);
    chk("basic_lat", out_valid, 0);
    beat(2'b01, 3'd3);
    chk("basic_valid", out_valid, 1);
    chk("basic_bits", out_bits, 8'b10110001);
    chk("basic_k", out_k, 3);
    chk("basic_cnt", beat_cnt, 0);
    chk("basic_rot", rot8(out_bits, int'(out_k)), 8'b00110110);
    step();
    chk("basic_drain", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    beat(2'b01, 3'd5);
    beat(2'b10, 3'd0);
    beat(2'b11, 3'd0);
    beat(2'b00, 3'd0);
    in_valid = 1'b1; in_data = 2'b11; in_k = 3'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", in_ready, 0);
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_bits", out_bits, 8'b01101100);
      chk("bp_k", out_k, 5);
      chk("bp_cnt", beat_cnt, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    x0 = xfers;
    step();
    chk("bp_drop", out_valid, 0);
    step();
    chk("bp_once", xfers - x0, 1);

    // back-to-back with k sampling on beats 1..3
    beat(2'b00, 3'd1);
    beat(2'b01, 3'd4);
    beat(2'b10, 3'd4);
    beat(2'b11, 3'd4);
    chk("b2b_a_valid", out_valid, 1);
    chk("b2b_a_bits", out_bits, 8'b00011011);
    chk("b2b_a_k", out_k, 1);
    in_valid = 1'b1; in_data = 2'b11; in_k = 3'd6;
    #1;
    chk("b2b_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b_v0", out_valid, 0);
    chk("b2b_cnt", beat_cnt, 1);
    beat(2'b10, 3'd2);
    chk("b2b_v1", out_valid, 0);
    beat(2'b01, 3'd7);
    chk("b2b_v2", out_valid, 0);
    beat(2'b00, 3'd0);
    chk("b2b_v3", out_valid, 1);
    chk("b2b_bits", out_bits, 8'b11100100);
    chk("ksamp_k", out_k, 6);
    step();
    chk("b2b_drain", out_valid, 0);

    // abort mid-FILL
    beat(2'b01, 3'd2);
    beat(2'b01, 3'd2);
    abort = 1'b1; in_valid = 1'b1; in_data = 2'b11;
    #1;
    chk("abt_ready", in_ready, 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abt_valid", out_valid, 0);
    chk("abt_cnt", beat_cnt, 0);
    chk("abt_keep_bits", out_bits, 8'b01010100);
    chk("abt_keep_k", out_k, 2);
    out_ready = 1'b0;
    beat(2'b00, 3'd4);
    beat(2'b11, 3'd1);
    beat(2'b00, 3'd1);
    beat(2'b11, 3'd1);
    chk("abt_new_valid", out_valid, 1);
    chk("abt_new_bits", out_bits, 8'b00110011);
    chk("abt_new_k", out_k, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_hold_valid", out_valid, 0);
    chk("abt_hold_bits", out_bits, 8'b00110011);
    #1;
    chk("abt_idle_ready", in_ready, 1);

    // W=N: one word per cycle
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 8'hA5; in_k1 = 3'd1;
    step();
    chk("w1_v0", out_valid1, 1);
    chk("w1_b0", out_bits1, 8'hA5);
    chk("w1_k0", out_k1, 1);
    in_data1 = 8'h3C; in_k1 = 3'd2;
    #1;
    chk("w1_ready", in_ready1, 1);
    step();
    chk("w1_v1", out_valid1, 1);
    chk("w1_b1", out_bits1, 8'h3C);
    chk("w1_k1", out_k1, 2);
    in_data1 = 8'hFF; in_k1 = 3'd7;
    step();
    chk("w1_b2", out_bits1, 8'hFF);
    chk("w1_k2", out_k1, 7);
    chk("w1_cnt", beat_cnt1, 0);
    in_valid1 = 1'b0;
    step();
    chk("w1_drain", out_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
